// File: rtl/fetch_buffer_pkg.sv
// Shared CPU front-end constants and the {pc, instr} entry type used by the fetch buffer.
package fetch_buffer_pkg;

   localparam int PC_WIDTH = 32;
   localparam int PC_STEP  = 4;
   localparam int FB_DEPTH = 4;
   localparam int FB_WIDTH = PC_WIDTH;

   typedef struct packed {
      logic [FB_WIDTH-1:0] pc;
      logic [FB_WIDTH-1:0] instr;
   } fb_entry_t;

endpackage

// File: rtl/fetch_buffer_if.sv
// Fetch-to-decode handshake bundle: fetch side (in_*), decode side (out_*), redirect flush.
interface fetch_buffer_if
   import fetch_buffer_pkg::*;
#(
   parameter int DEPTH = FB_DEPTH,
   parameter int WIDTH = FB_WIDTH
);
   logic [WIDTH-1:0]         in_pc;
   logic [WIDTH-1:0]         in_instr;
   logic                     in_valid;
   logic                     in_ready;
   logic                     pc_stall;
   logic [WIDTH-1:0]         out_pc;
   logic [WIDTH-1:0]         out_instr;
   logic                     out_valid;
   logic                     out_ready;
   logic                     flush;
   logic [$clog2(DEPTH):0]   count;

   modport master (
      output in_pc, in_instr, in_valid, out_ready, flush,
      input  in_ready, pc_stall, out_pc, out_instr, out_valid, count
   );

   modport slave (
      input  in_pc, in_instr, in_valid, out_ready, flush,
      output in_ready, pc_stall, out_pc, out_instr, out_valid, count
   );
endinterface

// File: rtl/fetch_buffer_ram.sv
// Entry storage: one synchronous write port, one asynchronous read port, contents not reset.
module fetch_buffer_ram #(
   parameter int DEPTH = 4,
   parameter int DW    = 64
) (
   input  logic                     clock,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [DW-1:0]            wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [DW-1:0]            rd_data
);
   logic [DW-1:0] mem_q [DEPTH];

   always_ff @(posedge clock) begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
   end

   assign rd_data = mem_q[rd_addr];
endmodule

// File: rtl/fetch_buffer.sv
// Fetch buffer between PC/imem and decode: FIFO of {pc, instr} with flush and PC stall.
module fetch_buffer
   import fetch_buffer_pkg::*;
#(
   parameter int DEPTH = FB_DEPTH,
   parameter int WIDTH = FB_WIDTH
) (
   input  logic          clock,
   input  logic          reset,
   fetch_buffer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0]      head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]      count_q, count_d;
   logic               full, empty, enq, deq;
   logic [2*WIDTH-1:0] rd_data;

   // Ready/valid come from the registered count only, so out_ready never reaches in_ready.
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign enq   = bus.in_valid && !full && !bus.flush;
   assign deq   = bus.out_ready && !empty && !bus.flush;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (bus.flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (enq) tail_d = tail_q + AW'(1);
         if (deq) head_d = head_q + AW'(1);
         case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   fetch_buffer_ram #(
      .DEPTH (DEPTH),
      .DW    (2*WIDTH)
   ) u_ram (
      .clock   (clock),
      .wr_en   (enq),
      .wr_addr (tail_q),
      .wr_data ({bus.in_pc, bus.in_instr}),
      .rd_addr (head_q),
      .rd_data (rd_data)
   );

   // Storage is never reset, so the head is masked while empty.
   assign bus.out_pc    = empty ? '0 : rd_data[2*WIDTH-1 -: WIDTH];
   assign bus.out_instr = empty ? '0 : rd_data[WIDTH-1:0];
   assign bus.out_valid = !empty;
   assign bus.in_ready  = !full;
   assign bus.pc_stall  = full;
   assign bus.count     = count_q;
endmodule

// File: tb/tb_fetch_buffer.sv
// Directed + random bench for fetch_buffer against a queue-based reference model.
module tb_fetch_buffer;
   import fetch_buffer_pkg::*;

   localparam int DEPTH = 4;
   localparam int WIDTH = 32;

   logic clock = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   fb_entry_t model_q[$];
   logic [31:0] next_pc;

   always #5 clock = ~clock;

   fetch_buffer_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

   fetch_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Outputs depend only on state, so they are checked against the model before the edge.
   task automatic check_state();
      int n;
      n = model_q.size();
      chk("count",     32'(bus.count),     32'(n));
      chk("out_valid", 32'(bus.out_valid), 32'(n != 0));
      chk("in_ready",  32'(bus.in_ready),  32'(n < DEPTH));
      chk("pc_stall",  32'(bus.pc_stall),  32'(n == DEPTH));
      chk("out_pc",    bus.out_pc,         (n != 0) ? model_q[0].pc : 32'h0);
      chk("out_instr", bus.out_instr,      (n != 0) ? model_q[0].instr : 32'h0);
   endtask

   // One clock: drive at negedge, check, advance model, return at next negedge.
   task automatic cycle(input logic rst, input logic fl, input logic iv,
                        input logic [31:0] pc, input logic [31:0] ins, input logic ordy);
      int  n;
      fb_entry_t e;
      reset         = rst;
      bus.flush     = fl;
      bus.in_valid  = iv;
      bus.in_pc     = pc;
      bus.in_instr  = ins;
      bus.out_ready = ordy;
      #1;
      check_state();
      n = model_q.size();
      if (rst || fl) begin
         model_q.delete();
      end else begin
         if (ordy && n > 0) void'(model_q.pop_front());
         if (iv && n < DEPTH) begin
            e.pc    = pc;
            e.instr = ins;
            model_q.push_back(e);
         end
      end
      @(negedge clock);
   endtask

   task automatic fill4(input logic [31:0] base);
      for (int i = 0; i < 4; i++) cycle(0, 0, 1, base + 32'(4*i), 32'h11 * 32'(i+1), 0);
   endtask

   initial begin
      reset = 1'b1;
      bus.flush = 0; bus.in_valid = 0; bus.in_pc = 0; bus.in_instr = 0; bus.out_ready = 0;
      @(negedge clock);
      @(negedge clock);
      model_q.delete();

      // Reset then idle.
      cycle(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 1);
      chk("idle_in_ready", 32'(bus.in_ready), 32'd1);

      // Fill to full; fifth pair is dropped; drain in order.
      fill4(32'h0);
      chk("full_count", 32'(bus.count), 32'd4);
      chk("full_stall", 32'(bus.pc_stall), 32'd1);
      cycle(0, 0, 1, 32'h10, 32'h55, 0);
      for (int i = 0; i < 4; i++) begin
         chk("drain_pc",    bus.out_pc,    32'(4*i));
         chk("drain_instr", bus.out_instr, 32'h11 * 32'(i+1));
         cycle(0, 0, 0, 0, 0, 1);
      end
      chk("drained_valid", 32'(bus.out_valid), 32'd0);

      // Streaming with pointer wrap.
      for (int i = 0; i < 20; i++) cycle(0, 0, 1, 32'h200 + 32'(4*i), $urandom, 1);
      chk("stream_count", 32'(bus.count), 32'd1);
      chk("stream_head", bus.out_pc, 32'h200 + 32'(4*19));
      cycle(0, 0, 0, 0, 0, 1);

      // Full plus dequeue: input rejected, count 3 next cycle.
      fill4(32'h300);
      cycle(0, 0, 1, 32'h3F0, 32'h99, 1);
      chk("fulldeq_count", 32'(bus.count), 32'd3);
      chk("fulldeq_ready", 32'(bus.in_ready), 32'd1);
      chk("fulldeq_head",  bus.out_pc, 32'h304);

      // Flush at count 3 drops the presented pair; next enqueue becomes head.
      cycle(0, 1, 1, 32'h40, 32'hAA, 0);
      chk("flush_count", 32'(bus.count), 32'd0);
      chk("flush_valid", 32'(bus.out_valid), 32'd0);
      cycle(0, 0, 1, 32'h80, 32'hBB, 0);
      chk("post_flush_head", bus.out_pc, 32'h80);

      // Reset and flush together at count 2, then random traffic.
      cycle(0, 0, 1, 32'h84, 32'hCC, 0);
      chk("pre_rst_count", 32'(bus.count), 32'd2);
      cycle(1, 1, 1, 32'h88, 32'hDD, 1);
      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_out_pc", bus.out_pc, 32'h0);
      chk("rst_stall", 32'(bus.pc_stall), 32'd0);

      next_pc = 32'h1000;
      for (int i = 0; i < 400; i++) begin
         logic rst, fl, iv, ordy;
         logic [31:0] pc;
         rst  = ($urandom_range(0, 59) == 0);
         fl   = ($urandom_range(0, 14) == 0);
         iv   = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 2) != 0);
         pc   = next_pc;
         if (iv && !rst && !fl && model_q.size() < DEPTH) next_pc = next_pc + PC_STEP;
         cycle(rst, fl, iv, pc, $urandom, ordy);
      end
      cycle(0, 0, 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter: DEPTH, 4, number of {pc, instr} entries; power of two, 2..16.
REQ-002 Parameter: WIDTH, 32, bit width of pc and instr fields.
REQ-003 Port: clock  in  1  single clock; all state updates on posedge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: in_pc  in  WIDTH  address of the fetched instruction, as produced by the PC register.
REQ-006 Port: in_instr  in  WIDTH  instruction word read from instruction memory at in_pc.
REQ-007 Port: in_valid  in  1  in_pc/in_instr pair is valid this cycle.
REQ-008 Port: in_ready  out  1  buffer accepts a pair this cycle.
REQ-009 Port: pc_stall  out  1  hold the PC; equals ~in_ready.
REQ-010 Port: out_pc  out  WIDTH  pc of the head entry.
REQ-011 Port: out_instr  out  WIDTH  instr of the head entry.
REQ-012 Port: out_valid  out  1  head entry present.
REQ-013 Port: out_ready  in  1  decode consumes the head entry this cycle.
REQ-014 Port: flush  in  1  branch/jump redirect; discard all entries.
REQ-015 Port: count  out  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-016 Enqueue occurs when in_valid && in_ready && !flush; the pair is written at the tail and the tail pointer advances by 1 mod DEPTH.
REQ-017 Dequeue occurs when out_valid && out_ready && !flush; the head pointer advances by 1 mod DEPTH.
REQ-018 in_ready = (count < DEPTH); it is derived from registered count only, with no combinational path from out_ready (no full-pass-through).
REQ-019 out_valid = (count != 0); out_pc/out_instr reflect the head entry combinationally from storage; when count == 0 they are driven to 0.
REQ-020 Latency: a pair enqueued in cycle N is visible on out_* in cycle N+1 at the earliest; there is no bypass path from in_* to out_*.
REQ-021 Simultaneous enqueue and dequeue with 0 < count < DEPTH: count is unchanged, both pointers advance.
REQ-022 Full (count == DEPTH): in_ready = 0, pc_stall = 1; in_valid is ignored; a dequeue in the same cycle frees a slot, and in_ready rises in the next cycle.
REQ-023 Empty (count == 0): out_ready is ignored; an enqueue makes count = 1 in the next cycle.
REQ-024 Pointer wrap-around: pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 without loss; count distinguishes full from empty.
REQ-025 flush has priority over enqueue and dequeue: next-cycle count = 0 and head = tail = 0; the in_* pair presented in the flush cycle is dropped.
REQ-026 Entry order is strictly FIFO; no entry is duplicated or reordered.

Reset
REQ-027 On reset in any cycle, including mid-operation: next cycle count = 0, head = tail = 0, out_valid = 0, out_pc = out_instr = 0, in_ready = 1, pc_stall = 0.
REQ-028 Reset has priority over flush, enqueue and dequeue.
REQ-029 Storage array contents need no reset; out_* are masked to 0 while empty.

Structure
REQ-030 Default DEPTH and WIDTH constants, and the {pc, instr} entry type, live in the shared CPU package alongside PC width constants.
REQ-031 Pointer and count logic is implemented in a single module; the storage array is a natural sub-module named fetch_buffer_ram (DEPTH x 2*WIDTH, one synchronous write port, one asynchronous read port).

Verification
REQ-032 Reset then idle: count = 0, out_valid = 0, in_ready = 1, pc_stall = 0, out_pc = 0.
REQ-033 Enqueue pc = 0x0, 0x4, 0x8, 0xC (instr 0x11..0x44) with out_ready = 0 -> count = 4, in_ready = 0, pc_stall = 1; a fifth pc = 0x10 is dropped; draining yields 0x0, 0x4, 0x8, 0xC in order.
REQ-034 Streaming: in_valid = out_ready = 1 for 20 cycles with pc incrementing by 4 -> count stays 1 after the first cycle; output sequence equals input sequence delayed by 1 cycle; pointers wrap at least 4 times.
REQ-035 Full plus dequeue in the same cycle with in_valid = 1 -> that cycle's input is rejected, count = 3 next cycle, in_ready = 1.
REQ-036 flush asserted with count = 3 and in_valid = 1 (pc = 0x40) -> next cycle count = 0, out_valid = 0; a subsequent enqueue of pc = 0x80 appears as the head.
REQ-037 reset and flush asserted together with count = 2, then random traffic -> state matches REQ-027; a scoreboard shows no lost or duplicated entries afterwards.
